pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register for the 0dMIPS datapath, sitting between pipeline stages (e.g. IF/ID, ID/EX).
- Extends the plain enable register with a valid/ready handshake on both sides, a one-entry skid buffer for full throughput under back-pressure, and a synchronous flush for branch/exception squash.
- One-cycle latency, one transfer per cycle sustained.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VALUE, 0, value driven on out_data after reset or flush (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept a payload this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid payload
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  payload to next stage

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-low.
- All state updates occur on the rising edge of clk. Nothing is asynchronous.
- Storage:
  - main entry: out_valid, out_data.
  - skid entry: skid_valid, skid_data (internal).
- in_ready = !skid_valid. It is a registered value with no combinational path from out_ready.
- Handshakes:
  - Upstream accept = in_valid && in_ready.
  - Downstream take = out_valid && out_ready.
- Update rules (priority order):
  1. rst==0:
     - out_valid=0, skid_valid=0.
     - out_data=RESET_VALUE, skid_data=RESET_VALUE.
     - in_ready reads 1 on the next cycle.
     - Inputs are ignored while rst==0.
  2. flush==1:
     - out_valid=0, skid_valid=0, out_data=RESET_VALUE.
     - Any accept in the same cycle is discarded.
     - A take in the same cycle completes downstream; the block does not retract it.
  3. Main free (out_valid==0 or out_ready==1):
     - If skid_valid: main<=skid and skid_valid<=0. An upstream accept this cycle cannot occur, because in_ready==0.
     - Else if accept: main<=in_data and out_valid<=1.
     - Else: out_valid<=0. out_data holds its last value, which is don't-care.
  4. Main stalled (out_valid==1 and out_ready==0):
     - main holds.
     - If accept: skid<=in_data and skid_valid<=1.
- Guarantees:
  - Latency from accept to out_valid is 1 cycle when unstalled.
  - Back-to-back accepts are possible every cycle while out_ready==1.
  - out_data and out_valid are stable while out_valid && !out_ready; no drop or duplicate.
  - Order is preserved: the skid entry is always younger than the main entry.
- Capacity: 2 entries.
  - Full = skid_valid, which gives in_ready==0.
  - Empty = !out_valid, which implies !skid_valid.
- Simultaneous accept and take while the skid is empty: main is replaced by in_data and out_valid stays 1.
- Behaviour is independent of in_data while in_valid==0.
- Reset mid-stream: all held payloads are lost and in_ready==1 on the cycle after rst returns to 1.

Optional Feature:
- Macro PIPE_STAGE_REG_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cycles (output, 32 bits).
  - The counter increments every cycle with out_valid && !out_ready and flush==0.
  - It is cleared to 0 by rst==0 only; flush does not clear it.
  - It saturates at 32'hFFFFFFFF.
- When undefined: no port, no counter logic, and the datapath behaviour is identical.

Test Plan:
- Reset: rst=0 for 2 cycles with WIDTH=32, RESET_VALUE=32'hDEAD_BEEF, in_valid=1 -> out_valid=0, out_data=32'hDEADBEEF, in_ready=1 after release; nothing accepted during reset.
- Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each, out_valid continuously 1, in_ready continuously 1.
- Back-pressure/skid:
  - Stimulus: send 5, then 6, while out_ready=0.
  - Response: out_data=5 held, skid takes 6, in_ready=0.
  - Then in_valid=1 with in_data=7 held and out_ready=1 for 2 cycles.
  - Response: outputs 5 then 6, 7 is accepted only after in_ready=1, final order 5,6,7 with no loss or duplicate.
- Flush: with both entries full (8 in main, 9 in skid), flush=1 with in_valid=1, in_data=10 -> next cycle out_valid=0, in_ready=1, out_data=RESET_VALUE; 10 is never output.
- Flush vs reset: flush=1 and rst=0 together -> reset result; with PIPE_STAGE_REG_STALL_CNT_EN, stall_cycles=0.
- Stall counter (macro on): hold one entry with out_ready=0 for 3 cycles, then 1 flushed cycle -> stall_cycles=3, retained after flush.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Elastic valid/ready pipeline register with one-entry skid buffer
//            and synchronous flush. Define PIPE_STAGE_REG_STALL_CNT_EN to add
//            the saturating stall_cycles output.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic [WIDTH-1:0] out_data
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    logic             w_accept;
    logic             w_main_free;

    // in_ready comes straight from a flop, so there is no path from out_ready
    assign in_ready    = !r_skid_valid;
    assign w_accept    = in_valid && !r_skid_valid;
    assign w_main_free = !r_out_valid || out_ready;

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= RESET_VALUE;
            r_skid_data  <= RESET_VALUE;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= RESET_VALUE;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= in_data;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            // main is stalled: the younger payload parks in the skid entry
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    localparam logic [31:0] c_stall_max = 32'hFFFF_FFFF;

    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (r_out_valid && !out_ready && !flush &&
                     (r_stall_cycles != c_stall_max)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench for pipe_stage_reg using a queue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int          c_width = 32;
    localparam logic [31:0] c_rv    = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    pipe_stage_reg #(
        .WIDTH       (c_width),
        .RESET_VALUE (c_rv)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] q[$];
    bit          known  = 1'b1;
    logic [31:0] m_stall = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare registered outputs mid-cycle, then advance the reference model.
    task automatic cycle();
        bit acc;
        bit tk;
        @(negedge clk);
        check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0)
            check("out_data", out_data, q[0]);
        else if (known)
            check("idle_data", out_data, c_rv);
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        check("stall_cycles", stall_cycles, m_stall);
`endif
        acc = in_valid && (q.size() < 2);
        tk  = (q.size() > 0) && out_ready;
        if (!rst) begin
            q.delete();
            known   = 1'b1;
            m_stall = '0;
        end else if (flush) begin
            q.delete();
            known = 1'b1;
        end else begin
            if (q.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF)
                m_stall = m_stall + 32'd1;
            if (tk) void'(q.pop_front());
            if (acc) q.push_back(in_data);
            if (tk && q.size() == 0) known = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        cycle();
    endtask

    initial begin
        // reset with upstream pushing: nothing may be captured
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b1;

        // streaming at full rate
        for (int i = 1; i <= 4; i++) drive(1'b1, i, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // back-pressure fills main and skid, then drains in order 5,6,7
        drive(1'b1, 32'd5, 1'b0, 1'b0);
        drive(1'b1, 32'd6, 1'b0, 1'b0);
        drive(1'b1, 32'd7, 1'b1, 1'b0);
        drive(1'b1, 32'd7, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);

        // flush with both entries held and an upstream offer of 10
        drive(1'b1, 32'd8, 1'b0, 1'b0);
        drive(1'b1, 32'd9, 1'b0, 1'b0);
        drive(1'b1, 32'd10, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);

        // flush and reset together: reset wins
        drive(1'b1, 32'd12, 1'b0, 1'b0);
        drive(1'b1, 32'd13, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 32'd14, 1'b1, 1'b1);
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);

        // one entry stalled three cycles, then a flushed stall cycle
        drive(1'b1, 32'd11, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        check("stall_after_flush", stall_cycles, 32'd3);
`endif

        // random traffic with occasional flushes
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0));
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
